fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

LC-3 instruction-fetch sequencer that sits directly downstream of the 16-bit PC register and feeds its load path. The sequencer:
- samples the PC into the MAR and drives the register's D input with PC+1 plus a one-cycle load enable;
- runs the memory read handshake;
- latches the fetched word into the IR and holds it for the decode stage under a valid/ack handshake.

It implements states FETCH1–FETCH3 of the LC-3 microsequence, plus idle and fault handling.

## Interface
Parameters:
- WAIT_LIMIT, default 8: maximum number of FETCH2 cycles to wait for mem_ready before faulting; must be ≥1.

Ports:
- clk  in  1  system clock; all sequencer state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin fetching; sampled only in IDLE.
- halt  in  1  stop after the current instruction is acknowledged.
- pc_q  in  16  current PC, taken from the PC register Q output.
- pc_next  out  16  next-PC value, driven to the PC register D input.
- ld_pc  out  1  PC register enable; high for exactly one cycle per fetch.
- mar_out  out  16  memory address register.
- mem_en  out  1  memory read request.
- mem_ready  in  1  memory read data valid.
- mem_data  in  16  memory read data.
- ir_out  out  16  instruction register.
- ir_valid  out  1  ir_out holds an instruction not yet consumed.
- decode_ack  in  1  decode stage has consumed ir_out.
- fault  out  1  memory timeout occurred; sticky.

## Operation
- States: IDLE, FETCH1, FETCH2, HOLD; state register is 2 bits.
- Wait counter: width ceil(log2(WAIT_LIMIT+1)); cleared on entry to FETCH2.
- pc_next = pc_q + 1, combinational, modulo 2^16. 0xFFFF wraps to 0x0000, with no flag.
- Moore outputs:
  - ld_pc = (state==FETCH1)
  - mem_en = (state==FETCH2)
  - ir_valid = (state==HOLD)
- IDLE:
  - if start & !halt: mar_out ← pc_q, fault ← 0, go to FETCH1.
  - otherwise stay in IDLE.
- FETCH1: PC register captures pc_next at the falling edge inside this cycle. Go to FETCH2 and clear the wait counter.
- FETCH2, priority order:
  - If mem_ready: ir_out ← mem_data, go to HOLD.
  - Else if count == WAIT_LIMIT−1: fault ← 1, go to IDLE; ir_out unchanged.
  - Else count ← count+1 and stay in FETCH2.
- HOLD:
  - if decode_ack & halt: go to IDLE.
  - if decode_ack & !halt: mar_out ← pc_q (the already-incremented PC), go to FETCH1.
  - otherwise stay in HOLD; ir_out is stable.
- start is ignored outside IDLE. halt is ignored outside IDLE and HOLD.
- mar_out changes only on entry to FETCH1. This guarantees mar_out holds the pre-increment PC throughout FETCH1 and FETCH2.

## Timing
- Reset values:
  - state IDLE
  - mar_out 0x0000, ir_out 0x0000
  - ir_valid 0, mem_en 0, ld_pc 0, fault 0
  - wait counter 0
- pc_next is not registered and follows pc_q.
- Reset mid-operation: all registers take their reset values at the next rising edge, and any in-flight fetch is abandoned. ld_pc is low from that edge onward. The PC register's own contents are not touched by this block.
- Latency, start to ir_valid: 3 cycles with zero-wait memory (mem_ready high in the first FETCH2 cycle). Add one cycle per FETCH2 cycle without mem_ready.
- Throughput: with decode_ack high in the first HOLD cycle, one instruction every 3 cycles.
- mem_ready arriving in the same cycle the counter reaches WAIT_LIMIT−1: ready wins and no fault is raised.
- decode_ack while not in HOLD: ignored.
- mem_ready outside FETCH2: ignored.
- fault stays high until the next accepted start or reset.

## Test plan
- Reset, then pc_q=0x3000, start pulse, mem_ready=1 with mem_data=0x1234:
  - ld_pc high in cycle 1 with pc_next=0x3001;
  - mar_out=0x3000 during cycles 1–2;
  - ir_out=0x1234 and ir_valid=1 from cycle 3.
- Back-to-back fetch with decode_ack held high and the PC model incrementing: mar_out sequence 0x3000, 0x3001, 0x3002; ir_valid pulses every 3 cycles; ld_pc asserted exactly once per fetch.
- Wait states with WAIT_LIMIT=8: mem_ready delayed 7 cycles → no fault, ir_valid 10 cycles after start. mem_ready never asserted → fault=1 and return to IDLE after 8 FETCH2 cycles; ir_out keeps its previous value.
- Wrap-around: pc_q=0xFFFF → pc_next=0x0000 and mar_out=0xFFFF. Halt: halt=1 with decode_ack in HOLD → IDLE, no further ld_pc.
- Reset asserted during FETCH2 and during HOLD → all outputs at reset values next cycle. A subsequent start refetches from the current pc_q; a start issued while in HOLD is ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// LC-3 instruction-fetch sequencer (FETCH1..FETCH3 of the microsequence plus
// idle and timeout handling). Sits downstream of the 16-bit PC register:
// samples the PC into the MAR, drives PC+1 back to the register with a
// one-cycle load enable, runs the memory read handshake and holds the fetched
// word in the IR until the decode stage acknowledges it.
//
// Parameters:
//   WAIT_LIMIT  max FETCH2 cycles to wait for mem_ready before faulting (>=1)
//
// Ports:
//   clk         system clock, rising-edge
//   reset       synchronous active-high reset
//   start       begin fetching (only looked at while idle)
//   halt        stop after the current instruction is acknowledged
//   pc_q        current PC from the PC register Q output
//   pc_next     PC+1 (mod 2^16) to the PC register D input
//   ld_pc       PC register load enable, one cycle per fetch
//   mar_out     memory address register
//   mem_en      memory read request
//   mem_ready   memory read data valid
//   mem_data    memory read data
//   ir_out      instruction register
//   ir_valid    ir_out holds an instruction not yet consumed
//   decode_ack  decode stage has consumed ir_out
//   fault       sticky memory-timeout flag
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int WAIT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic [15:0] pc_q,
  output logic [15:0] pc_next,
  output logic        ld_pc,
  output logic [15:0] mar_out,
  output logic        mem_en,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  input  logic        decode_ack,
  output logic        fault
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH1 = 2'd1,
    FETCH2 = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   mar_q, mar_d;
  logic [15:0]   ir_q, ir_d;
  logic          fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (start && !halt) begin
          mar_d   = pc_q;
          fault_d = 1'b0;
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        // PC register loads pc_next during this cycle; mar_out keeps the
        // pre-increment address for the whole read.
        cnt_d   = '0;
        state_d = FETCH2;
      end
      FETCH2: begin
        // Ready has priority over timeout on the last allowed cycle.
        if (mem_ready) begin
          ir_d    = mem_data;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (decode_ack) begin
          if (halt) begin
            state_d = IDLE;
          end else begin
            // pc_q already holds the incremented PC from the last FETCH1.
            mar_d   = pc_q;
            state_d = FETCH1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mar_q   <= 16'h0000;
      ir_q    <= 16'h0000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  assign pc_next  = pc_q + 16'd1;
  assign ld_pc    = (state_q == FETCH1);
  assign mem_en   = (state_q == FETCH2);
  assign ir_valid = (state_q == HOLD);
  assign mar_out  = mar_q;
  assign ir_out   = ir_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A transaction-level model tracks where
// a fetch is (cycles since it began, whether an instruction is held) and is
// compared with the DUT every cycle after reset. Hand-computed literal
// expectations, scheduled by cycle number, pin key points of the scenarios.
// The PC register is modelled here: it loads pc_next at the falling edge
// while ld_pc is high.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int WL = 8;

  localparam int S_LD  = 0;
  localparam int S_PCN = 1;
  localparam int S_MAR = 2;
  localparam int S_IR  = 3;
  localparam int S_IRV = 4;
  localparam int S_FLT = 5;
  localparam int S_MEM = 6;

  logic        clk = 1'b0;
  logic        reset, start, halt, mem_ready, decode_ack;
  logic [15:0] mem_data;
  logic [15:0] pc_reg;
  logic        pc_wr;
  logic [15:0] pc_wr_val;
  logic [15:0] pc_next, mar_out, ir_out;
  logic        ld_pc, mem_en, ir_valid, fault;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit armed   = 1'b0;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [15:0] val;
  } lit_t;
  lit_t lit_arr [0:127];
  int   lit_n   = 0;
  int   lit_idx = 0;

  // model state
  bit          m_busy, m_hold, m_fault;
  int          m_age;
  logic [15:0] m_mar, m_ir;

  fetch_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt       (halt),
    .pc_q       (pc_reg),
    .pc_next    (pc_next),
    .ld_pc      (ld_pc),
    .mar_out    (mar_out),
    .mem_en     (mem_en),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .decode_ack (decode_ack),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // PC register
  initial begin
    pc_reg = 16'h0000;
    forever begin
      @(negedge clk);
      if (ld_pc) pc_reg = pc_next;
      else if (pc_wr) pc_reg = pc_wr_val;
    end
  end

  // Transaction-level model: m_age counts cycles since a fetch began
  // (0 = address/PC-load cycle, k>=1 = k-th memory wait cycle).
  initial begin
    m_busy = 0; m_hold = 0; m_fault = 0; m_age = 0;
    m_mar = 16'h0; m_ir = 16'h0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 0; m_hold = 0; m_fault = 0; m_age = 0;
        m_mar = 16'h0; m_ir = 16'h0;
      end else if (m_hold) begin
        if (decode_ack) begin
          m_hold = 0;
          if (!halt) begin
            m_busy = 1; m_age = 0; m_mar = pc_reg;
          end
        end
      end else if (m_busy) begin
        if (m_age == 0) begin
          m_age = 1;
        end else if (mem_ready) begin
          m_ir = mem_data; m_hold = 1; m_busy = 0;
        end else if (m_age == WL) begin
          m_fault = 1; m_busy = 0;
        end else begin
          m_age = m_age + 1;
        end
      end else if (start && !halt) begin
        m_busy = 1; m_age = 0; m_mar = pc_reg; m_fault = 0;
      end
    end
  end

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      S_LD:    return {15'd0, ld_pc};
      S_PCN:   return pc_next;
      S_MAR:   return mar_out;
      S_IR:    return ir_out;
      S_IRV:   return {15'd0, ir_valid};
      S_FLT:   return {15'd0, fault};
      default: return {15'd0, mem_en};
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Single compare process: model checks every cycle, plus scheduled literals.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) armed = 1'b1;
      cyc++;
      #2;
      if (armed) begin
        check("ld_pc",    {15'd0, ld_pc},    {15'd0, m_busy && m_age == 0});
        check("mem_en",   {15'd0, mem_en},   {15'd0, m_busy && m_age >= 1});
        check("ir_valid", {15'd0, ir_valid}, {15'd0, m_hold});
        check("fault",    {15'd0, fault},    {15'd0, m_fault});
        check("mar_out",  mar_out, m_mar);
        check("ir_out",   ir_out,  m_ir);
        check("pc_next",  pc_next, pc_reg + 16'd1);
      end
      while (lit_idx < lit_n && lit_arr[lit_idx].cyc <= cyc) begin
        check(lit_arr[lit_idx].name, pick(lit_arr[lit_idx].sel), lit_arr[lit_idx].val);
        lit_idx++;
      end
    end
  end

  task automatic add_lit(input int dc, input string nm, input int sel, input logic [15:0] v);
    lit_arr[lit_n] = '{cyc + dc, nm, sel, v};
    lit_n++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setpc(input logic [15:0] v);
    pc_wr_val = v;
    pc_wr = 1'b1;
    @(negedge clk);
    #1 pc_wr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; start = 0; halt = 0; mem_ready = 0; decode_ack = 0;
    mem_data = 16'h0; pc_wr = 0; pc_wr_val = 16'h0;
    tick(2);
    reset = 0;
    add_lit(0, "rst_mar", S_MAR, 16'h0000);
    add_lit(0, "rst_ir",  S_IR,  16'h0000);
    add_lit(0, "rst_irv", S_IRV, 16'h0);
    add_lit(0, "rst_flt", S_FLT, 16'h0);
    add_lit(0, "rst_ld",  S_LD,  16'h0);
    add_lit(0, "rst_mem", S_MEM, 16'h0);
    $display("[TB] reset released");

    // single zero-wait fetch
    setpc(16'h3000);
    mem_ready = 1; mem_data = 16'h1234; start = 1;
    add_lit(1, "t1_ld",     S_LD,  16'h1);
    add_lit(1, "t1_pcnext", S_PCN, 16'h3001);
    add_lit(1, "t1_mar_c1", S_MAR, 16'h3000);
    add_lit(2, "t1_mar_c2", S_MAR, 16'h3000);
    add_lit(2, "t1_mem_en", S_MEM, 16'h1);
    add_lit(3, "t1_ir",     S_IR,  16'h1234);
    add_lit(3, "t1_irv",    S_IRV, 16'h1);
    tick(1); start = 0;
    tick(2); mem_ready = 0; mem_data = 16'h5555;
    tick(2);
    add_lit(0, "t1_hold_ir", S_IR, 16'h1234);
    start = 1;
    add_lit(1, "t1_start_in_hold_ld",  S_LD,  16'h0);
    add_lit(1, "t1_start_in_hold_irv", S_IRV, 16'h1);
    tick(1); start = 0;
    $display("[TB] single fetch from 0x3000 done");

    // back-to-back fetches with decode_ack held
    decode_ack = 1; mem_ready = 1; mem_data = 16'h1111;
    add_lit(1, "t2_mar1", S_MAR, 16'h3001);
    add_lit(1, "t2_ld1",  S_LD,  16'h1);
    add_lit(2, "t2_ld1_once", S_LD, 16'h0);
    add_lit(3, "t2_irv1", S_IRV, 16'h1);
    add_lit(3, "t2_ir1",  S_IR,  16'h1111);
    add_lit(4, "t2_mar2", S_MAR, 16'h3002);
    add_lit(4, "t2_ld2",  S_LD,  16'h1);
    add_lit(5, "t2_irv_gap", S_IRV, 16'h0);
    add_lit(6, "t2_irv2", S_IRV, 16'h1);
    tick(6);
    $display("[TB] back-to-back fetch 0x3001,0x3002 done");

    // halt with ack in HOLD
    halt = 1;
    add_lit(1, "t3_halt_irv", S_IRV, 16'h0);
    add_lit(1, "t3_halt_ld",  S_LD,  16'h0);
    add_lit(2, "t3_halt_ld2", S_LD,  16'h0);
    tick(1);
    decode_ack = 0; mem_ready = 0;
    start = 1;  // blocked by halt
    add_lit(1, "t3_start_halt_ld", S_LD, 16'h0);
    tick(1); start = 0; halt = 0;
    tick(1);
    $display("[TB] halt done");

    // seven wait states, ready on the last allowed cycle
    start = 1;
    add_lit(1,  "t4_mar",     S_MAR, 16'h3003);
    add_lit(9,  "t4_mem_en9", S_MEM, 16'h1);
    add_lit(9,  "t4_irv9",    S_IRV, 16'h0);
    add_lit(10, "t4_irv10",   S_IRV, 16'h1);
    add_lit(10, "t4_ir",      S_IR,  16'hBEEF);
    add_lit(10, "t4_flt",     S_FLT, 16'h0);
    tick(1); start = 0;
    tick(8); mem_ready = 1; mem_data = 16'hBEEF;
    tick(1); mem_ready = 0; mem_data = 16'h0; halt = 1; decode_ack = 1;
    add_lit(1, "t4_release", S_IRV, 16'h0);
    tick(1); halt = 0; decode_ack = 0;
    $display("[TB] 7-wait fetch done");

    // timeout
    start = 1;
    add_lit(9,  "t5_mem_en9", S_MEM, 16'h1);
    add_lit(9,  "t5_flt9",    S_FLT, 16'h0);
    add_lit(10, "t5_flt10",   S_FLT, 16'h1);
    add_lit(10, "t5_mem_en10", S_MEM, 16'h0);
    add_lit(10, "t5_irv",     S_IRV, 16'h0);
    add_lit(10, "t5_ir_kept", S_IR,  16'hBEEF);
    tick(1); start = 0;
    tick(9); mem_ready = 1; mem_data = 16'h7777;
    add_lit(1, "t5_late_ready_ir",  S_IR,  16'hBEEF);
    add_lit(1, "t5_late_ready_irv", S_IRV, 16'h0);
    add_lit(1, "t5_flt_sticky",     S_FLT, 16'h1);
    tick(1); mem_ready = 0;
    tick(1);
    start = 1; mem_ready = 1; mem_data = 16'h2222;
    add_lit(1, "t5_flt_cleared", S_FLT, 16'h0);
    add_lit(1, "t5_restart_ld",  S_LD,  16'h1);
    tick(1); start = 0;
    tick(2); halt = 1; decode_ack = 1;
    tick(1); halt = 0; decode_ack = 0; mem_ready = 0;
    $display("[TB] timeout and recovery done");

    // wrap-around
    setpc(16'hFFFF);
    add_lit(0, "t6_pcn_ffff", S_PCN, 16'h0000);
    mem_ready = 1; mem_data = 16'hCAFE; start = 1;
    add_lit(1, "t6_mar1", S_MAR, 16'hFFFF);
    add_lit(1, "t6_pcn1", S_PCN, 16'h0000);
    add_lit(2, "t6_mar2", S_MAR, 16'hFFFF);
    add_lit(2, "t6_pcn2", S_PCN, 16'h0001);
    add_lit(3, "t6_ir",   S_IR,  16'hCAFE);
    tick(1); start = 0;
    tick(2);
    $display("[TB] wrap-around fetch done");

    // reset during FETCH2
    decode_ack = 1; mem_ready = 0;
    tick(1); decode_ack = 0;
    tick(1); reset = 1;
    add_lit(1, "t7_rst_mar", S_MAR, 16'h0000);
    add_lit(1, "t7_rst_ir",  S_IR,  16'h0000);
    add_lit(1, "t7_rst_irv", S_IRV, 16'h0);
    add_lit(1, "t7_rst_mem", S_MEM, 16'h0);
    add_lit(1, "t7_rst_ld",  S_LD,  16'h0);
    add_lit(1, "t7_rst_flt", S_FLT, 16'h0);
    tick(1); reset = 0;
    start = 1; mem_ready = 1; mem_data = 16'h4321;
    add_lit(1, "t7_refetch_mar", S_MAR, 16'h0001);
    add_lit(1, "t7_refetch_ld",  S_LD,  16'h1);
    add_lit(3, "t7_refetch_ir",  S_IR,  16'h4321);
    tick(1); start = 0;
    tick(3);
    // reset during HOLD
    reset = 1;
    add_lit(1, "t7_hold_rst_irv", S_IRV, 16'h0);
    add_lit(1, "t7_hold_rst_ir",  S_IR,  16'h0000);
    add_lit(1, "t7_hold_rst_mar", S_MAR, 16'h0000);
    tick(1); reset = 0; mem_ready = 0;
    tick(3);
    $display("[TB] reset during FETCH2/HOLD done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
